// File: rtl/rgb_hue_fader.sv
// Hue-wheel RGB driver: steps or fades through R-Y-G-C-B-M and drives three
// PWM LED pins with frame-aligned duty updates and global brightness scaling.
module rgb_hue_fader #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 46875,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [PWM_BITS-1:0] bright,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic [2:0]          seg,
  output logic                wrap
);

  localparam int unsigned N      = PWM_BITS;
  localparam int unsigned BR_W   = N + 1;
  localparam int unsigned PROD_W = 2 * N + 1;
  localparam int unsigned CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [N-1:0]     MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [2:0]       LED_IDLE = {3{ACTIVE_LOW}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       seg_q, seg_d;
  logic [N-1:0]     level_q, level_d;
  logic             wrap_q, wrap_d;
  logic [N-1:0]     p_q, p_d;
  logic [N-1:0]     duty_r_q, duty_r_d;
  logic [N-1:0]     duty_g_q, duty_g_d;
  logic [N-1:0]     duty_b_q, duty_b_d;
  logic [2:0]       led_q, led_d;

  logic             tick_c;
  logic             advance_c;
  logic [N-1:0]     raw_r_c, raw_g_c, raw_b_c;

  // (raw * (bright+1)) >> N; bright = MAX leaves raw untouched
  function automatic logic [N-1:0] scale(input logic [N-1:0] raw,
                                         input logic [N-1:0] br);
    logic [BR_W-1:0]   gain;
    logic [PROD_W-1:0] prod;
    gain = BR_W'(br) + BR_W'(1);
    prod = PROD_W'(raw) * PROD_W'(gain);
    return N'(prod >> N);
  endfunction

  // Tick counter and hue position
  always_comb begin
    cnt_d     = cnt_q;
    seg_d     = seg_q;
    level_d   = level_q;
    advance_c = 1'b0;
    tick_c    = en && (cnt_q == CNT_LAST);

    if (en) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (tick_c) begin
      if (!mode || (level_q == MAX)) begin
        advance_c = 1'b1;
        level_d   = '0;
      end else begin
        level_d = level_q + N'(1);
      end
    end

    if (advance_c) begin
      seg_d = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
    end

    wrap_d = advance_c && (seg_q == 3'd5);
  end

  // Unscaled colour for the current segment and level
  always_comb begin
    raw_r_c = '0;
    raw_g_c = '0;
    raw_b_c = '0;
    if (mode) begin
      unique case (seg_q)
        3'd0: begin raw_r_c = MAX;           raw_g_c = level_q;       end
        3'd1: begin raw_r_c = MAX - level_q; raw_g_c = MAX;           end
        3'd2: begin raw_g_c = MAX;           raw_b_c = level_q;       end
        3'd3: begin raw_g_c = MAX - level_q; raw_b_c = MAX;           end
        3'd4: begin raw_r_c = level_q;       raw_b_c = MAX;           end
        3'd5: begin raw_r_c = MAX;           raw_b_c = MAX - level_q; end
        default: ;
      endcase
    end else begin
      unique case (seg_q)
        3'd0: begin raw_r_c = MAX;                     end
        3'd1: begin raw_r_c = MAX; raw_g_c = MAX;      end
        3'd2: begin raw_g_c = MAX;                     end
        3'd3: begin raw_g_c = MAX; raw_b_c = MAX;      end
        3'd4: begin raw_b_c = MAX;                     end
        3'd5: begin raw_r_c = MAX; raw_b_c = MAX;      end
        default: ;
      endcase
    end
  end

  // PWM counter; duties only reload on the last cycle of a frame
  always_comb begin
    p_d      = p_q + N'(1);
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    if (p_q == MAX) begin
      duty_r_d = scale(raw_r_c, bright);
      duty_g_d = scale(raw_g_c, bright);
      duty_b_d = scale(raw_b_c, bright);
    end
    led_d = {(p_q < duty_r_q), (p_q < duty_g_q), (p_q < duty_b_q)} ^ LED_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      seg_q    <= '0;
      level_q  <= '0;
      wrap_q   <= 1'b0;
      p_q      <= '0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
      led_q    <= LED_IDLE;
    end else begin
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
      level_q  <= level_d;
      wrap_q   <= wrap_d;
      p_q      <= p_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      led_q    <= led_d;
    end
  end

  assign RGB_R = led_q[2];
  assign RGB_G = led_q[1];
  assign RGB_B = led_q[0];
  assign seg   = seg_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Bench for rgb_hue_fader: a behavioural hue/PWM model checked every cycle
// against an active-high and an active-low instance, plus literal window counts.
module tb_rgb_hue_fader;

  localparam int N    = 3;
  localparam int STEP = 4;
  localparam int M    = 7;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] bright;

  logic       r0, g0, b0, wrap0;
  logic [2:0] seg0;
  logic       r1, g1, b1, wrap1;
  logic [2:0] seg1;

  rgb_hue_fader #(.PWM_BITS(N), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .bright(bright),
    .RGB_R(r0), .RGB_G(g0), .RGB_B(b0), .seg(seg0), .wrap(wrap0)
  );

  rgb_hue_fader #(.PWM_BITS(N), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .bright(bright),
    .RGB_R(r1), .RGB_G(g1), .RGB_B(b1), .seg(seg1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state; cyc counts clock edges since reset release
  int cyc;
  int m_cnt, m_seg, m_lvl, m_wrap, m_p;
  int m_duty[3];
  int m_led[3];
  int m_tick, m_adv;

  int w_r0, w_g0, w_b0, w_r1, w_g1, w_b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Colour table of the hue wheel, channel c = 0/1/2 for R/G/B
  function automatic int raw_of(input int c, input int s, input int l, input bit md);
    int rgb[3];
    rgb = '{0, 0, 0};
    if (md) begin
      case (s)
        0: rgb = '{M, l, 0};
        1: rgb = '{M - l, M, 0};
        2: rgb = '{0, M, l};
        3: rgb = '{0, M - l, M};
        4: rgb = '{l, 0, M};
        5: rgb = '{M, 0, M - l};
        default: rgb = '{0, 0, 0};
      endcase
    end else begin
      case (s)
        0: rgb = '{M, 0, 0};
        1: rgb = '{M, M, 0};
        2: rgb = '{0, M, 0};
        3: rgb = '{0, M, M};
        4: rgb = '{0, 0, M};
        5: rgb = '{M, 0, M};
        default: rgb = '{0, 0, 0};
      endcase
    end
    return rgb[c];
  endfunction

  // Behavioural model, advanced on every active edge
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0; m_cnt = 0; m_seg = 0; m_lvl = 0; m_wrap = 0; m_p = 0;
        for (int c = 0; c < 3; c++) begin
          m_duty[c] = 0;
          m_led[c]  = 0;
        end
      end else begin
        m_tick = (en && m_cnt == STEP - 1) ? 1 : 0;
        m_adv  = 0;
        for (int c = 0; c < 3; c++) m_led[c] = (m_p < m_duty[c]) ? 1 : 0;
        if (m_p == M)
          for (int c = 0; c < 3; c++)
            m_duty[c] = (raw_of(c, m_seg, m_lvl, mode) * (int'(bright) + 1)) / (M + 1);
        m_p = (m_p + 1) % (M + 1);
        if (en) m_cnt = (m_cnt + 1) % STEP;
        if (m_tick != 0) begin
          if (!mode || m_lvl == M) m_adv = 1;
          else m_lvl = m_lvl + 1;
        end
        m_wrap = (m_adv != 0 && m_seg == 5) ? 1 : 0;
        if (m_adv != 0) begin
          m_seg = (m_seg + 1) % 6;
          m_lvl = 0;
        end
        cyc++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("seg_hi", int'(seg0), m_seg);
        check("wrap_hi", int'(wrap0), m_wrap);
        check("r_hi", int'(r0), m_led[0]);
        check("g_hi", int'(g0), m_led[1]);
        check("b_hi", int'(b0), m_led[2]);
        check("seg_lo", int'(seg1), m_seg);
        check("wrap_lo", int'(wrap1), m_wrap);
        check("r_lo", int'(r1), 1 - m_led[0]);
        check("g_lo", int'(g1), 1 - m_led[1]);
        check("b_lo", int'(b1), 1 - m_led[2]);
      end
    end
  end

  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    while (cyc != k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) check("wait_timeout", cyc, k);
  endtask

  // Count high cycles of every pin over cycles from..to inclusive
  task automatic count_win(input int from, input int to);
    w_r0 = 0; w_g0 = 0; w_b0 = 0; w_r1 = 0; w_g1 = 0; w_b1 = 0;
    wait_cyc(from);
    for (int i = from; i <= to; i++) begin
      if (i != from) @(negedge clk);
      w_r0 += int'(r0); w_g0 += int'(g0); w_b0 += int'(b0);
      w_r1 += int'(r1); w_g1 += int'(g1); w_b1 += int'(b1);
    end
  endtask

  task automatic do_reset(input bit md, input bit e, input logic [2:0] br);
    @(negedge clk);
    #1;
    rst = 1'b1; mode = md; en = e; bright = br;
    repeat (3) @(negedge clk);
    check("rst_seg", int'(seg0), 0);
    check("rst_wrap", int'(wrap0), 0);
    check("rst_rgb_hi", int'({r0, g0, b0}), 0);
    check("rst_rgb_lo", int'({r1, g1, b1}), 7);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; bright = 3'd7;
    @(negedge clk);
    chk_en = 1'b1;

    // Step mode at full brightness
    do_reset(1'b0, 1'b1, 3'd7);
    wait_cyc(3);  check("step_seg_c3", int'(seg0), 0);
    wait_cyc(4);  check("step_seg_c4", int'(seg0), 1);
    count_win(9, 16);
    check("step_seg1_r", w_r0, 7);
    check("step_seg1_g", w_g0, 7);
    check("step_seg1_b", w_b0, 0);
    check("step_seg1_r_lo", w_r1, 1);
    wait_cyc(23); check("step_wrap_c23", int'(wrap0), 0);
    wait_cyc(24); check("step_wrap_c24", int'(wrap0), 1);
    check("step_seg_c24", int'(seg0), 0);
    wait_cyc(25); check("step_wrap_c25", int'(wrap0), 0);
    wait_cyc(30);

    // Fade mode, entered through a mid-run reset
    do_reset(1'b1, 1'b1, 3'd7);
    count_win(0, 8);
    check("first_frame_hi", w_r0 + w_g0 + w_b0, 0);
    check("first_frame_lo", w_r1, 9);
    count_win(9, 16);  check("fade_g_f1", w_g0, 1); check("fade_r_f1", w_r0, 7);
    count_win(17, 24); check("fade_g_f2", w_g0, 3);
    check("fade_seg_c24", int'(seg0), 0);
    count_win(25, 32); check("fade_g_f3", w_g0, 5);
    check("fade_seg_c32", int'(seg0), 1);
    count_win(41, 48); check("fade_r_f5", w_r0, 6); check("fade_g_f5", w_g0, 7);

    // Pause for 50 cycles in segment 2
    wait_cyc(69); #1; en = 1'b0;
    count_win(73, 80);
    check("pause_g", w_g0, 7);
    check("pause_b", w_b0, 1);
    wait_cyc(118); check("pause_seg", int'(seg0), 2);
    wait_cyc(119); #1; en = 1'b1;
    count_win(129, 136);
    check("resume_b", w_b0, 3);

    // Brightness scaling, hue frozen in segment 0
    do_reset(1'b0, 1'b0, 3'd3);
    fork
      count_win(9, 16);
      begin
        wait_cyc(12);
        #1;
        bright = 3'd0;
      end
    join
    check("bright3_r", w_r0, 3);
    check("bright3_g", w_g0, 0);
    count_win(17, 24); check("bright0_r", w_r0, 0);
    check("bright0_r_lo", w_r1, 8);
    wait_cyc(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

endmodule
